// File: rtl/ones_mod4_pkg.sv
// ones_mod4_pkg: shared types and constants for the ones_mod4 frame
// transmitter.
//   state_t  : FSM states, IDLE / DATA / PAD
//   PAD_W    : number of pad bits appended after the payload
//   pad_ones : number of leading pad ones needed to bring the frame's count
//              of ones to a multiple of 4, given the payload ones count mod 4
package ones_mod4_pkg;

  localparam int PAD_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2
  } state_t;

  // (4 - cnt) mod 4 is simply the 2-bit two's complement of cnt.
  function automatic logic [1:0] pad_ones(input logic [1:0] cnt);
    return 2'd0 - cnt;
  endfunction

endpackage

// File: rtl/ones_mod4_frame_tx_if.sv
// ones_mod4_frame_tx_if: word-in / bit-out bus of the frame transmitter.
//   din, din_valid   : parallel payload word offered by the producer
//   din_ready        : transmitter accepts a word this cycle
//   dout, dout_valid : serial frame bit and its qualifier
//   frame_done       : pulse on the last pad bit of each frame
// Handshake: a word transfers on a rising clk edge where din_valid and
// din_ready are both 1; din is captured at that edge. din_valid while
// din_ready is 0 has no effect. dout/dout_valid carry no backpressure.
interface ones_mod4_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              dout;
  logic              dout_valid;
  logic              frame_done;

  modport master (
    output din, din_valid,
    input  din_ready, dout, dout_valid, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dout, dout_valid, frame_done
  );
endinterface

// File: rtl/ones_mod4_counter.sv
// ones_mod4_counter: 2-bit count of payload ones, modulo 4.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count at 0 (a new word was accepted)
//   inc        : a payload 1 was emitted this cycle
//   count      : ones seen so far, wrapping 3 -> 0
module ones_mod4_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
    end else if (clear) begin
      count <= 2'd0;
    end else if (inc) begin
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/ones_mod4_frame_tx.sv
// ones_mod4_frame_tx: serializes each accepted DATA_W-bit word, MSB first,
// followed by PAD_W pad bits whose leading ones make the frame's total count
// of ones a multiple of 4.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of ones_mod4_frame_tx_if (din/din_valid/din_ready
//                in, dout/dout_valid/frame_done out)
//   state_dbg  : current FSM state, for observation only
module ones_mod4_frame_tx
  import ones_mod4_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ones_mod4_frame_tx_if.slave   bus,
  output state_t                state_dbg
);

  localparam int          BL_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [1:0]  PAD_LAST = 2'(PAD_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;      // payload bits not yet placed on dout
  logic [BL_W-1:0]   bits_left;  // payload bits still to follow the current one
  logic [1:0]        pad_idx;    // index of the pad bit currently on dout
  logic              dout_q;
  logic              dout_valid_q;
  logic              frame_done_q;

  logic              din_ready;
  logic              hs;
  logic              inc;
  logic [1:0]        cnt;
  logic [1:0]        cnt_final;
  logic [1:0]        k_data;
  logic [1:0]        k_pad;

  // Ready in IDLE or while the last pad bit is out, so back-to-back frames
  // run without a gap. Forced low in reset so a word cannot be lost then.
  assign din_ready = !reset &&
                     ((state == IDLE) || ((state == PAD) && (pad_idx == PAD_LAST)));
  assign hs        = bus.din_valid && din_ready;

  // The counter tracks bits already emitted; the bit on dout this cycle is
  // folded in at the edge that leaves it.
  assign inc       = (state == DATA) && dout_q;

  // On the edge leaving the last payload bit the counter has not yet absorbed
  // that bit, so the first pad bit uses the look-ahead sum. Later pad bits
  // use the settled count.
  assign cnt_final = cnt + {1'b0, dout_q};
  assign k_data    = pad_ones(cnt_final);
  assign k_pad     = pad_ones(cnt);

  ones_mod4_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (hs),
    .inc   (inc),
    .count (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bits_left    <= '0;
      pad_idx      <= 2'd0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (hs) begin
      // Only reachable from IDLE or the last pad bit: start a new frame with
      // the MSB on dout in the very next cycle.
      state        <= DATA;
      dout_q       <= bus.din[DATA_W-1];
      shreg        <= bus.din << 1;
      bits_left    <= BL_W'(DATA_W - 1);
      pad_idx      <= 2'd0;
      dout_valid_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dout_q       <= 1'b0;
          dout_valid_q <= 1'b0;
          frame_done_q <= 1'b0;
        end
        DATA: begin
          if (bits_left == '0) begin
            state        <= PAD;
            pad_idx      <= 2'd0;
            dout_q       <= (k_data != 2'd0);
            frame_done_q <= (PAD_LAST == 2'd0);
          end else begin
            dout_q    <= shreg[DATA_W-1];
            shreg     <= shreg << 1;
            bits_left <= bits_left - BL_W'(1);
          end
        end
        PAD: begin
          if (pad_idx == PAD_LAST) begin
            state        <= IDLE;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
          end else begin
            pad_idx      <= pad_idx + 2'd1;
            // Pad bit j is a one exactly when j < k.
            dout_q       <= ((pad_idx + 2'd1) < k_pad);
            frame_done_q <= ((pad_idx + 2'd1) == PAD_LAST);
          end
        end
        default: begin
          state        <= IDLE;
          dout_q       <= 1'b0;
          dout_valid_q <= 1'b0;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_done = frame_done_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_ones_mod4_frame_tx.sv
module tb_ones_mod4_frame_tx;
  import ones_mod4_pkg::*;

  localparam int W  = 8;
  localparam int FW = W + PAD_W;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  state_t state_dbg;

  always #5 clk = ~clk;

  ones_mod4_frame_tx_if #(.DATA_W(W)) bus ();

  ones_mod4_frame_tx #(.DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  logic          mq[$];        // expected serial bit stream, head = bit on dout now
  logic [W-1:0]  exp_q[$];     // payloads accepted, in order
  logic [FW-1:0] got_q[$];     // frames observed on dout
  logic [FW-1:0] cur_frame = '0;
  int            nbits     = 0;
  int            done_cnt  = 0;
  int            run_len   = 0;
  int            max_run   = 0;
  bit            cmp_en    = 1'b0;
  bit            m_hs;
  logic [FW-1:0] m_frame;
  logic          exp_v, exp_d, exp_fd;
  logic [FW-1:0] nf;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A frame is the word followed by k ones then zeros, k = (4 - ones mod 4) mod 4.
  function automatic logic [FW-1:0] frame_of(input logic [W-1:0] w);
    int k;
    logic [FW-1:0] f;
    k = (4 - ($countones(w) % 4)) % 4;
    f = {w, {PAD_W{1'b0}}};
    for (int j = 0; j < k; j++) f[PAD_W-1-j] = 1'b1;
    return f;
  endfunction

  // Ready whenever nothing is queued or only the frame's last bit remains.
  function automatic bit m_ready();
    return !reset && (mq.size() <= 1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      exp_q.delete();
    end else begin
      m_hs = bus.din_valid && m_ready();
      if (mq.size() > 0) void'(mq.pop_front());
      if (m_hs) begin
        m_frame = frame_of(bus.din);
        for (int i = FW - 1; i >= 0; i--) mq.push_back(m_frame[i]);
        exp_q.push_back(bus.din);
      end
    end
  end

  // ---------------- compare + serial ones-mod-4 checker ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_v  = (mq.size() > 0);
      exp_d  = exp_v ? mq[0] : 1'b0;
      exp_fd = (mq.size() == 1);
      check("dout_valid", 32'(bus.dout_valid), 32'(exp_v));
      check("dout",       32'(bus.dout),       32'(exp_d));
      check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
      check("din_ready",  32'(bus.din_ready),  32'(m_ready()));

      if (bus.dout_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        nf        = {cur_frame[FW-2:0], bus.dout};
        cur_frame = nf;
        nbits++;
        if (bus.frame_done) begin
          check("frame_len", 32'(nbits), 32'(FW));
          check("ones_mod4", 32'($countones(nf) % 4), 32'd0);
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL payload: frame %0h seen, no accepted word expected", nf);
          end else begin
            check("payload", 32'(nf[FW-1:PAD_W]), 32'(exp_q.pop_front()));
          end
          got_q.push_back(nf);
          done_cnt++;
          nbits = 0;
        end
      end else begin
        run_len = 0;
        nbits   = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    bus.din       = w;
    bus.din_valid = 1'b1;
    while (!m_ready() && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total_cnt++;
      $display("FAIL send_timeout: word=%0h waited=%0d cycles, required <100", w, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    bus.din_valid = 1'b0;
    while (mq.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total_cnt++;
      $display("FAIL drain_timeout: %0d bits still pending after %0d cycles, required 0", mq.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string name, input int idx, input logic [FW-1:0] exp);
    if (idx < got_q.size()) check(name, 32'(got_q[idx]), 32'(exp));
    else begin
      total_cnt++;
      $display("FAIL %s: frame %0d missing (got %0d frames), required %0h", name, idx, got_q.size(), exp);
    end
  endtask

  // ---------------- stimulus ----------------
  int done_base;

  initial begin
    bus.din       = '0;
    bus.din_valid = 1'b0;
    reset         = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_dout",       32'(bus.dout),       32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_din_ready",  32'(bus.din_ready),  32'd0);
    check("rst_state",      32'(state_dbg),      32'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.din_ready), 32'd1);

    // Scenario 1: all ones -> no pad ones, 11 valid cycles.
    got_q.delete(); max_run = 0;
    send(8'hFF);
    wait_idle();
    check("s1_count", 32'(got_q.size()), 32'd1);
    check_frame("s1_frame", 0, 11'b11111111_000);
    check("s1_valid_run", 32'(max_run), 32'd11);

    // Scenario 2: 1, 2 and 3 ones need 3, 2 and 1 pad ones.
    got_q.delete();
    send(8'h01); wait_idle();
    send(8'h03); wait_idle();
    send(8'h07); wait_idle();
    check_frame("s2_frame01", 0, 11'b00000001_111);
    check_frame("s2_frame03", 1, 11'b00000011_110);
    check_frame("s2_frame07", 2, 11'b00000111_100);

    // Scenario 3: back-to-back with din_valid held high.
    got_q.delete(); max_run = 0;
    send(8'hA5);
    send(8'h80);
    wait_idle();
    check_frame("s3_frameA5", 0, 11'b10100101_000);
    check_frame("s3_frame80", 1, 11'b10000000_111);
    check("s3_valid_run", 32'(max_run), 32'd22);

    // Scenario 4: din_valid during DATA is ignored.
    got_q.delete();
    send(8'h5A);
    idle(2);
    bus.din       = 8'h00;
    bus.din_valid = 1'b1;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    wait_idle();
    idle(15);
    check("s4_count", 32'(got_q.size()), 32'd1);
    check_frame("s4_frame", 0, 11'b01011010_000);

    // Scenario 5: reset during the 5th payload bit aborts the frame.
    got_q.delete(); done_cnt = 0;
    send(8'hC3);          // returns in the MSB cycle
    bus.din_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;         // now in the 5th payload bit cycle
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("s5_abort_valid", 32'(bus.dout_valid), 32'd0);
    idle(3);
    check("s5_no_done", 32'(done_cnt), 32'd0);
    send(8'h0F);
    wait_idle();
    check_frame("s5_frame0F", 0, 11'b00001111_000);

    // Scenario 6: random words with random gaps.
    done_base = done_cnt;
    for (int i = 0; i < 1000; i++) begin
      int g;
      send(W'($urandom_range(0, 255)));
      g = $urandom_range(0, 3);
      if (g > 0) idle(g);
    end
    wait_idle();
    check("s6_frames", 32'(done_cnt - done_base), 32'd1000);
    check("s6_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ones_mod4_frame_tx.md
ONES_MOD4_FRAME_TX -- requirements
Module: ones_mod4_frame_tx

Interface
REQ-001 Parameter: DATA_W, default 8, payload bits per frame (must be at least 1).
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: din  input  DATA_W  parallel payload word.
REQ-005 Port: din_valid  input  1  payload word offered.
REQ-006 Port: din_ready  output  1  block can accept a word this cycle.
REQ-007 Port: dout  output  1  serial frame bit.
REQ-008 Port: dout_valid  output  1  dout carries a frame bit this cycle.
REQ-009 Port: frame_done  output  1  one-cycle pulse coinciding with the last pad bit.

Function
REQ-010 The block SHALL serialize each accepted word into one frame of DATA_W+3 bits: DATA_W payload bits, MSB first, then 3 pad bits.
REQ-011 The pad SHALL contain k ones followed by 3-k zeros, where k = (4 - popcount(din) mod 4) mod 4, so that the total ones in the frame are a multiple of 4.
REQ-012 The FSM SHALL have exactly three states: IDLE, DATA and PAD. Transitions:
- IDLE->DATA on handshake.
- DATA->PAD after bit 0 is emitted.
- PAD->IDLE after the 3rd pad bit, with no handshake.
- PAD->DATA after the 3rd pad bit, with a handshake.
REQ-013 A handshake SHALL occur when din_valid and din_ready are both 1 at a rising edge; din SHALL be captured at that edge.
REQ-014 din_ready SHALL be 1 in IDLE and during the 3rd pad bit cycle, and 0 otherwise; din_valid at any other time SHALL be ignored with no state change.
REQ-015 Latency: the payload MSB SHALL appear on dout, with dout_valid=1, in the cycle immediately after the handshake edge.
REQ-016 dout_valid SHALL be 1 for exactly DATA_W+3 consecutive cycles per frame.
REQ-017 Back-to-back frames SHALL produce no dout_valid gap.
REQ-018 dout and dout_valid SHALL be registered outputs; dout SHALL be 0 whenever dout_valid=0.
REQ-019 A 2-bit ones counter SHALL clear on handshake, increment modulo 4 on each emitted payload 1, and wrap 3->0.
REQ-020 k SHALL be derived from the counter value after the last payload bit.
REQ-021 frame_done SHALL be 1 only in the cycle carrying the 3rd pad bit.

Reset
REQ-022 While reset is sampled high, the next state SHALL be IDLE, with the ones counter and shift register cleared.
REQ-023 Reset values: dout=0, dout_valid=0, frame_done=0.
REQ-024 din_ready SHALL be 0 during any cycle in which reset is high, and 1 from the first cycle after reset deasserts.
REQ-025 Reset mid-frame SHALL abort the frame immediately: no further frame bits are emitted and no frame_done pulse is generated.
REQ-026 Reset SHALL take priority over a simultaneous handshake, and the word SHALL be dropped.

Structure
REQ-027 Package ones_mod4_pkg SHALL hold the state enum (IDLE/DATA/PAD) and the constant PAD_W=3.
REQ-028 The modulo-4 ones counter SHALL be a sub-module, ones_mod4_counter, with clear, inc and 2-bit count ports.
REQ-029 The block SHALL have no other sub-modules and no latches.

Verification
REQ-030 Scenario 1: din=8'hFF, one handshake -> dout 1111_1111 then pad 000, dout_valid high for 11 cycles, frame_done in the 11th cycle.
REQ-031 Scenario 2: din=8'h01, then 8'h03, then 8'h07, each from IDLE -> pads 111, 110 and 100 respectively; every frame has a ones count that is a multiple of 4.
REQ-032 Scenario 3: din_valid held high with 8'hA5 then 8'h80 -> 22 contiguous valid bits: 10100101 000, then 10000000 111; din_ready high only in cycles 0 and 11.
REQ-033 Scenario 4: din_valid pulsed during DATA with 8'h00 -> ignored; the current frame is unaltered and no extra frame follows.
REQ-034 Scenario 5: reset asserted for 1 cycle during the 5th payload bit -> next cycle dout_valid=0 and no frame_done; a following handshake with 8'h0F yields 00001111 000.
REQ-035 Scenario 6: scoreboard against a serial ones-mod-4 checker, 1000 random words with random valid gaps -> every frame checks as a multiple of 4 and the payload matches.
